shifter_share_arbiter: RTL and testbench
========================================

Name: shifter_share_arbiter

Overview:
- Shares one combinational 6-bit rotator between two requesters (port 0 and port 1) in the ALU datapath.
- Each requester issues a rotate command through a valid/ready request channel and receives its result on its own valid/ready response channel.
- Arbitration is round-robin or fixed-priority, selected by parameter.
- Results are registered, giving a one-cycle compute latency and full back-to-back throughput when consumers do not stall.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority with port 0 always winning.
- W, 6, data width. Fixed at 6 to match the rotator; any other value is a configuration error.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  2  per-port command valid; bit i belongs to port i.
- req_ready  output  2  per-port command accepted this cycle.
- req_dir0, req_dir1  input  1  1 = rotate left, 0 = rotate right.
- req_shamt0, req_shamt1  input  3  rotate amount, 0..7.
- req_data0, req_data1  input  6  operand.
- rsp_valid  output  2  per-port result valid.
- rsp_ready  input  2  per-port result consumed.
- rsp_data  output  6  registered result; meaningful only while a rsp_valid bit is set.
- busy  output  1  high in state RESP.

Behaviour:
- Rotation semantics:
  - The result equals the operand rotated by shamt single-bit steps, so the effective amount is shamt mod 6.
  - shamt = 0 or 6 returns the operand unchanged; shamt = 7 behaves as shamt = 1.
  - Left: bit5 wraps to bit0. Right: bit0 wraps to bit5.
- FSM states: IDLE and RESP. State register owner (1 bit) records which port holds the result.
- Grant (combinational, among valid ports):
  - Only one port is valid: grant that port.
  - Both ports valid, RR_EN = 1: grant the port not equal to last_grant.
  - Both ports valid, RR_EN = 0: grant port 0.
- Accept condition (slot free):
  - In IDLE, the slot is free.
  - In RESP, the slot is free when rsp_ready[owner] = 1 in the same cycle, which gives pipelined pass-through.
  - When the slot is free and any req_valid is set, req_ready[grant] = 1. All other req_ready bits are 0.
- On accept (rising edge):
  - rsp_data <= rotator output for the granted port's command.
  - owner <= grant; last_grant <= grant; state <= RESP.
- In RESP:
  - rsp_valid[owner] = 1 and the other bit is 0.
  - rsp_data and owner hold stable until rsp_ready[owner] = 1.
  - rsp_ready on the non-owner port is ignored.
- Leaving RESP:
  - rsp_ready[owner] = 1 with no new accept: state <= IDLE.
  - rsp_ready[owner] = 1 with a new accept in the same cycle: stay in RESP with new data and owner.
- Latency: accept at edge N puts the result on rsp_data with rsp_valid set during cycle N+1.
- Throughput: one command per cycle while consumers keep rsp_ready high.
- Request side:
  - req_ready never depends on req_valid of the same port beyond the grant logic.
  - Commands are sampled only on the accept edge.
  - A requester must hold its command stable while req_valid = 1 and req_ready = 0.
- Reset:
  - Values after reset: state = IDLE, owner = 0, last_grant = 1 (so port 0 wins the first contention), rsp_data = 0, rsp_valid = 0, req_ready = 0, busy = 0.
  - Reset asserted in RESP discards the pending result. No response is delivered for it.
  - Reset has priority over every accept and drain.
- No X propagation: rsp_data is always driven from the register.

Decomposition:
- Shared package: state encodings ST_IDLE = 1'b0, ST_RESP = 1'b1; constants DIR_LEFT = 1'b1, DIR_RIGHT = 1'b0; W = 6.
- One sub-module: the existing combinational SixBitShifter (ports direction, shamt, xVal, shiftedVal), instantiated once. Its inputs are driven by the command mux selected by grant.
- The arbiter, FSM and result register live in this module.

Test Plan:
- Single port 0 command, left, shamt = 3, data 6'b000111, rsp_ready held 1. Expected: req_ready0 in cycle 0; rsp_valid[0] with rsp_data = 6'b111000 in cycle 1; return to IDLE in cycle 2.
- Port 1 command, right, shamt = 7, data 6'b000001 (wrap check). Expected: rsp_data = 6'b100000. Also shamt = 6 on data 6'b101100 returns 6'b101100.
- Both ports continuously valid, RR_EN = 1, rsp_ready = 2'b11. Expected grants 0,1,0,1 on consecutive cycles, with one response every cycle. With RR_EN = 0, port 0 is granted every cycle.
- Port 0 result pending with rsp_ready0 = 0 for 4 cycles while port 1 is valid. Expected: rsp_data and rsp_valid[0] stable, req_ready = 0 throughout. When rsp_ready0 rises, port 1 is accepted in that same cycle and its result appears in the next cycle.
- Non-owner rsp_ready1 = 1 while owner = 0. Expected: no state change and no drain.
- Reset pulsed for 1 cycle while in RESP with a pending result. Expected: next cycle rsp_valid = 0, busy = 0, rsp_data = 0. First contention after reset grants port 0.

Source files
------------

// File: rtl/shifter_share_arbiter_pkg.sv
// Shared definitions for the shared-rotator arbiter: FSM encodings,
// rotate-direction constants and the fixed datapath width.
package shifter_share_arbiter_pkg;

   localparam int W = 6;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

endpackage

// File: rtl/shifter_share_arbiter_shifter.sv
// Combinational 6-bit rotator. The rotate amount is taken modulo 6, so
// shamt 6 is a no-op and shamt 7 behaves as a single-step rotate.
module SixBitShifter
   import shifter_share_arbiter_pkg::*;
(
   input  logic       direction,
   input  logic [2:0] shamt,
   input  logic [5:0] xVal,
   output logic [5:0] shiftedVal
);

   logic [2:0]  amt;
   logic [3:0]  lsb;
   logic [11:0] dbl;

   // Reduce the amount mod 6, then pick a 6-bit window out of the doubled
   // operand; a left rotate by a is the window starting at 6-a, a right
   // rotate by a is the window starting at a.
   always_comb begin
      amt = (shamt >= 3'd6) ? (shamt - 3'd6) : shamt;
      dbl = {xVal, xVal};
      if (direction == DIR_LEFT) begin
         lsb = 4'd6 - {1'b0, amt};
      end else begin
         lsb = {1'b0, amt};
      end
      shiftedVal = dbl[lsb +: 6];
   end

endmodule

// File: rtl/shifter_share_arbiter.sv
// Two requesters share one rotator. A grant picks one pending command,
// the rotated result is registered and handed back on the winner's
// response channel. A result slot that drains in the same cycle can be
// refilled immediately, giving one command per cycle.
module shifter_share_arbiter
   import shifter_share_arbiter_pkg::*;
#(
   parameter int RR_EN = 1,
   parameter int W     = shifter_share_arbiter_pkg::W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic         req_dir0,
   input  logic         req_dir1,
   input  logic [2:0]   req_shamt0,
   input  logic [2:0]   req_shamt1,
   input  logic [W-1:0] req_data0,
   input  logic [W-1:0] req_data1,
   output logic [1:0]   rsp_valid,
   input  logic [1:0]   rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         busy
);

   generate
      if (W != 6) begin : g_bad_width
         $error("shifter_share_arbiter: W must be 6 to match the rotator");
      end
   endgenerate

   state_t       state_q, state_d;
   logic         owner_q, owner_d;
   logic         last_grant_q, last_grant_d;
   logic [W-1:0] rsp_data_q, rsp_data_d;

   logic         grant;
   logic         slot_free;
   logic         accept;
   logic         sh_dir;
   logic [2:0]   sh_shamt;
   logic [5:0]   sh_in;
   logic [5:0]   sh_out;

   // Pick a winner among the valid ports and steer its command into the
   // shared rotator; the slot is free when idle or when the current
   // result is being consumed this cycle.
   always_comb begin
      grant = 1'b0;
      unique case (req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = (RR_EN != 0) ? ~last_grant_q : 1'b0;
         default: grant = 1'b0;
      endcase

      slot_free = (state_q == ST_IDLE) || rsp_ready[owner_q];
      accept    = slot_free && (req_valid != 2'b00);

      req_ready = 2'b00;
      if (accept) begin
         req_ready[grant] = 1'b1;
      end

      if (grant) begin
         sh_dir   = req_dir1;
         sh_shamt = req_shamt1;
         sh_in    = req_data1;
      end else begin
         sh_dir   = req_dir0;
         sh_shamt = req_shamt0;
         sh_in    = req_data0;
      end
   end

   SixBitShifter u_shifter (
      .direction  (sh_dir),
      .shamt      (sh_shamt),
      .xVal       (sh_in),
      .shiftedVal (sh_out)
   );

   // Next-state logic: an accept always loads a fresh result (even while
   // draining the old one); otherwise a consumed result returns to idle.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      rsp_data_d   = rsp_data_q;

      if (accept) begin
         state_d      = ST_RESP;
         owner_d      = grant;
         last_grant_d = grant;
         rsp_data_d   = sh_out;
      end else if ((state_q == ST_RESP) && rsp_ready[owner_q]) begin
         state_d = ST_IDLE;
      end
   end

   // State and result registers; reset discards any pending result and
   // primes last_grant so port 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   // Response outputs come straight from the registered state.
   always_comb begin
      rsp_valid = 2'b00;
      if (state_q == ST_RESP) begin
         rsp_valid[owner_q] = 1'b1;
      end
      busy     = (state_q == ST_RESP);
      rsp_data = rsp_data_q;
   end

endmodule

// File: tb/tb_shifter_share_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority instance share
// the same stimulus and are each compared every cycle against an abstract
// model of the arbiter, plus directed literal expectations.
module tb_shifter_share_arbiter;

   logic       clk;
   logic       reset;
   logic [1:0] req_valid;
   logic       req_dir0, req_dir1;
   logic [2:0] req_shamt0, req_shamt1;
   logic [5:0] req_data0, req_data1;
   logic [1:0] rsp_ready;

   logic [1:0] req_ready_w [2];
   logic [1:0] rsp_valid_w [2];
   logic [5:0] rsp_data_w  [2];
   logic       busy_w      [2];

   int checks;
   int errors;

   // Abstract model, one slot per instance: is a result pending, for which
   // port, with what value, and who won most recently.
   bit       m_pend [2];
   bit       m_port [2];
   bit [5:0] m_data [2];
   bit       m_last [2];
   bit       m_rr   [2];

   shifter_share_arbiter #(.RR_EN(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready_w[0]),
      .req_dir0   (req_dir0),
      .req_dir1   (req_dir1),
      .req_shamt0 (req_shamt0),
      .req_shamt1 (req_shamt1),
      .req_data0  (req_data0),
      .req_data1  (req_data1),
      .rsp_valid  (rsp_valid_w[0]),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data_w[0]),
      .busy       (busy_w[0])
   );

   shifter_share_arbiter #(.RR_EN(0)) dut_fp (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready_w[1]),
      .req_dir0   (req_dir0),
      .req_dir1   (req_dir1),
      .req_shamt0 (req_shamt0),
      .req_shamt1 (req_shamt1),
      .req_data0  (req_data0),
      .req_data1  (req_data1),
      .rsp_valid  (rsp_valid_w[1]),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data_w[1]),
      .busy       (busy_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rotation as arithmetic: shift both ways and OR, amount taken mod 6.
   function automatic bit [5:0] rotModel(input bit dir, input int sh, input bit [5:0] x);
      int a;
      int v;
      a = sh % 6;
      v = x;
      if (dir) v = (v << a) | (v >> (6 - a));
      else     v = (v >> a) | (v << (6 - a));
      return 6'(v & 63);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s got %0h want %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit [1:0] v,
                                input bit d0, input bit [2:0] s0, input bit [5:0] x0,
                                input bit d1, input bit [2:0] s1, input bit [5:0] x1,
                                input bit [1:0] rr);
      @(posedge clk);
      #2;
      req_valid  = v;
      req_dir0   = d0;
      req_shamt0 = s0;
      req_data0  = x0;
      req_dir1   = d1;
      req_shamt1 = s1;
      req_data1  = x1;
      rsp_ready  = rr;
   endtask

   task automatic sampleCycle();
      @(negedge clk);
      #1;
   endtask

   // Compare every cycle against the model, then advance the model using
   // the inputs that will be seen by the next rising edge.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         bit       win;
         bit       free;
         bit       acc;
         bit [1:0] expReady;
         bit [1:0] expValid;
         bit       cDir;
         bit [2:0] cSh;
         bit [5:0] cX;

         if (req_valid == 2'b11) win = (m_rr[k] && !m_last[k]) ? 1'b1 : 1'b0;
         else                    win = req_valid[1];
         free     = !m_pend[k] || rsp_ready[m_port[k]];
         acc      = free && (req_valid != 2'b00);
         expReady = acc ? (win ? 2'b10 : 2'b01) : 2'b00;
         expValid = m_pend[k] ? (m_port[k] ? 2'b10 : 2'b01) : 2'b00;

         if (!reset) begin
            checkOutput($sformatf("req_ready[%0d]", k), req_ready_w[k], expReady);
            checkOutput($sformatf("rsp_valid[%0d]", k), rsp_valid_w[k], expValid);
            checkOutput($sformatf("busy[%0d]", k), busy_w[k], m_pend[k]);
            if (m_pend[k]) checkOutput($sformatf("rsp_data[%0d]", k), rsp_data_w[k], m_data[k]);
         end

         cDir = win ? req_dir1   : req_dir0;
         cSh  = win ? req_shamt1 : req_shamt0;
         cX   = win ? req_data1  : req_data0;
         if (reset) begin
            m_pend[k] = 1'b0;
            m_port[k] = 1'b0;
            m_data[k] = 6'd0;
            m_last[k] = 1'b1;
         end else if (acc) begin
            m_pend[k] = 1'b1;
            m_port[k] = win;
            m_data[k] = rotModel(cDir, int'(cSh), cX);
            m_last[k] = win;
         end else if (m_pend[k] && rsp_ready[m_port[k]]) begin
            m_pend[k] = 1'b0;
         end
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      m_rr[0]  = 1'b1;
      m_rr[1]  = 1'b0;
      m_last[0] = 1'b1;
      m_last[1] = 1'b1;
      reset      = 1'b1;
      req_valid  = 2'b00;
      req_dir0   = 1'b0;
      req_dir1   = 1'b0;
      req_shamt0 = 3'd0;
      req_shamt1 = 3'd0;
      req_data0  = 6'd0;
      req_data1  = 6'd0;
      rsp_ready  = 2'b11;

      // Pin the model's rotation against hand-computed values.
      checkOutput("model_left3",  rotModel(1'b1, 3, 6'b000111), 6'b111000);
      checkOutput("model_right7", rotModel(1'b0, 7, 6'b000001), 6'b100000);
      checkOutput("model_right6", rotModel(1'b0, 6, 6'b101100), 6'b101100);
      checkOutput("model_left1",  rotModel(1'b1, 1, 6'b100001), 6'b000011);

      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      sampleCycle();
      checkOutput("reset_busy",  busy_w[0], 0);
      checkOutput("reset_valid", rsp_valid_w[0], 0);
      checkOutput("reset_data",  rsp_data_w[0], 0);

      // Single port 0 command, left by 3.
      applyStimulus(2'b01, 1'b1, 3'd3, 6'b000111, 1'b0, 3'd0, 6'd0, 2'b11);
      sampleCycle();
      checkOutput("t1_ready", req_ready_w[0], 2'b01);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);
      sampleCycle();
      checkOutput("t1_valid", rsp_valid_w[0], 2'b01);
      checkOutput("t1_data",  rsp_data_w[0], 6'b111000);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);
      sampleCycle();
      checkOutput("t1_idle", busy_w[0], 0);

      // Port 1 wrap checks, back to back.
      applyStimulus(2'b10, 1'b0, 3'd0, 6'd0, 1'b0, 3'd7, 6'b000001, 2'b11);
      sampleCycle();
      checkOutput("t2_ready", req_ready_w[0], 2'b10);
      applyStimulus(2'b10, 1'b0, 3'd0, 6'd0, 1'b0, 3'd6, 6'b101100, 2'b11);
      sampleCycle();
      checkOutput("t2_data7",   rsp_data_w[0], 6'b100000);
      checkOutput("t2_ready_b", req_ready_w[0], 2'b10);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);
      sampleCycle();
      checkOutput("t2_data6", rsp_data_w[0], 6'b101100);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);

      // Continuous contention: round-robin alternates, fixed priority sticks.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(2'b11, 1'b1, 3'(i), 6'(i + 5), 1'b0, 3'(i + 1), 6'(40 - i), 2'b11);
         sampleCycle();
         checkOutput($sformatf("t3_rr_%0d", i), req_ready_w[0], (i % 2 == 0) ? 2'b01 : 2'b10);
         checkOutput($sformatf("t3_fp_%0d", i), req_ready_w[1], 2'b01);
      end
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);

      // Port 0 result stalls while port 1 waits; non-owner ready is ignored.
      applyStimulus(2'b01, 1'b0, 3'd1, 6'b000110, 1'b0, 3'd0, 6'd0, 2'b10);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(2'b10, 1'b0, 3'd1, 6'b000110, 1'b1, 3'd2, 6'b010001, 2'b10);
         sampleCycle();
         checkOutput($sformatf("t4_hold_ready_%0d", i), req_ready_w[0], 2'b00);
         checkOutput($sformatf("t4_hold_valid_%0d", i), rsp_valid_w[0], 2'b01);
         checkOutput($sformatf("t4_hold_data_%0d", i),  rsp_data_w[0], 6'b000011);
      end
      applyStimulus(2'b10, 1'b0, 3'd1, 6'b000110, 1'b1, 3'd2, 6'b010001, 2'b11);
      sampleCycle();
      checkOutput("t4_release_ready", req_ready_w[0], 2'b10);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);
      sampleCycle();
      checkOutput("t4_p1_valid", rsp_valid_w[0], 2'b10);
      checkOutput("t4_p1_data",  rsp_data_w[0], 6'b000101);

      // Reset while a result is pending discards it.
      applyStimulus(2'b01, 1'b1, 3'd2, 6'b001001, 1'b0, 3'd0, 6'd0, 2'b00);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b00);
      sampleCycle();
      checkOutput("t5_pending", busy_w[0], 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      sampleCycle();
      checkOutput("t5_valid", rsp_valid_w[0], 0);
      checkOutput("t5_busy",  busy_w[0], 0);
      checkOutput("t5_data",  rsp_data_w[0], 0);
      applyStimulus(2'b11, 1'b0, 3'd1, 6'b000010, 1'b1, 3'd1, 6'b000010, 2'b11);
      sampleCycle();
      checkOutput("t5_rr_first",  req_ready_w[0], 2'b01);
      checkOutput("t5_fp_first",  req_ready_w[1], 2'b01);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);
      sampleCycle();
      checkOutput("t5_rr_result", rsp_data_w[0], 6'b000001);
      applyStimulus(2'b00, 1'b0, 3'd0, 6'd0, 1'b0, 3'd0, 6'd0, 2'b11);
      sampleCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
